// File: rtl/jp_macro_player.sv
// Joypad script player: replays {buttons, hold frames} entries timed by vblank rising edges and
// passes live pad vectors through when idle. Define JP_MACRO_MERGE_EN to OR live presses into playback.
module jp_macro_player #(
    parameter int NUM_PLAYERS = 2,
    parameter int BTN_W       = 10,
    parameter int DEPTH       = 16,
    parameter int DUR_W       = 16,
    localparam int VEC_W      = NUM_PLAYERS * BTN_W,
    localparam int AW         = $clog2(DEPTH),
    localparam int ENT_W      = VEC_W + DUR_W
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_vblank,
    input  logic [VEC_W-1:0]   i_jp_vec,
    input  logic               i_wr_en,
    input  logic [AW-1:0]      i_wr_addr,
    input  logic [ENT_W-1:0]   i_wr_data,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic               i_loop,
    output logic [VEC_W-1:0]   o_jp_vec,
    output logic               o_busy,
    output logic [AW-1:0]      o_step,
    output logic               o_done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_APPLY = 3'd2,
        S_HOLD  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [AW-1:0]      ptr_q, ptr_d;
    logic [DUR_W-1:0]   cnt_q, cnt_d;
    logic [VEC_W-1:0]   out_q, out_d;
    logic               vblank_q;
    logic               vb_rise;
    logic               end_hit;

    logic [ENT_W-1:0]   mem [DEPTH];
    logic [ENT_W-1:0]   rd_q;
    logic [VEC_W-1:0]   rd_btn;
    logic [DUR_W-1:0]   rd_dur;

`ifdef JP_MACRO_MERGE_EN
    logic [VEC_W-1:0]   btn_q, btn_d;
`endif

    // Script RAM: read data is registered and reflects contents before a same-cycle write.
    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            mem[i_wr_addr] <= i_wr_data;
        end
        rd_q <= mem[ptr_q];
    end

    assign rd_btn  = rd_q[VEC_W-1:0];
    assign rd_dur  = rd_q[ENT_W-1:VEC_W];
    assign vb_rise = i_vblank & ~vblank_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            ptr_q    <= '0;
            cnt_q    <= '0;
            out_q    <= '0;
            vblank_q <= 1'b0;
`ifdef JP_MACRO_MERGE_EN
            btn_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            vblank_q <= i_vblank;
`ifdef JP_MACRO_MERGE_EN
            btn_q    <= btn_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        end_hit = 1'b0;
`ifdef JP_MACRO_MERGE_EN
        btn_d   = btn_q;
`endif
        case (state_q)
            S_IDLE: begin
                out_d = i_jp_vec;
                if (i_start) begin
                    ptr_d   = '0;
                    state_d = S_FETCH;
`ifdef JP_MACRO_MERGE_EN
                    btn_d   = '0;
`endif
                end
            end
            S_FETCH: begin
                state_d = S_APPLY;
            end
            S_APPLY: begin
                if (rd_dur == '0) begin
                    end_hit = 1'b1;
                end else begin
                    out_d   = rd_btn;
                    cnt_d   = rd_dur;
                    state_d = S_HOLD;
`ifdef JP_MACRO_MERGE_EN
                    btn_d   = rd_btn;
`endif
                end
            end
            S_HOLD: begin
                if (vb_rise) begin
                    if (cnt_q == DUR_W'(1)) begin
                        // Running off the last entry behaves exactly like hitting an end marker.
                        if (ptr_q == AW'(DEPTH - 1)) begin
                            end_hit = 1'b1;
                        end else begin
                            ptr_d   = ptr_q + AW'(1);
                            state_d = S_FETCH;
                        end
                    end else begin
                        cnt_d = cnt_q - DUR_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                ptr_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                ptr_d   = '0;
            end
        endcase

        // A marker at entry 0 never loops, so an empty script cannot spin forever.
        if (end_hit) begin
            if (i_loop && (ptr_q != '0)) begin
                ptr_d   = '0;
                state_d = S_FETCH;
            end else begin
                state_d = S_DONE;
            end
        end

`ifdef JP_MACRO_MERGE_EN
        if (state_q != S_IDLE) begin
            out_d = btn_d | i_jp_vec;
        end
`endif

        if (i_stop) begin
            state_d = S_IDLE;
            ptr_d   = '0;
        end
    end

    assign o_jp_vec = out_q;
    assign o_busy   = (state_q != S_IDLE);
    assign o_step   = ptr_q;
    assign o_done   = (state_q == S_DONE);

endmodule

// File: tb/tb_jp_macro_player.sv
// Self-checking bench for jp_macro_player: cycle tables, directed corner sequences and
// randomized scripts checked against a frame-timeline model.
module tb_jp_macro_player;

    localparam int NP    = 2;
    localparam int BW    = 10;
    localparam int DEPTH = 16;
    localparam int DW    = 16;
    localparam int VW    = NP * BW;
    localparam int AW    = 4;
    localparam int EW    = VW + DW;
    localparam logic [VW-1:0] LIVE = 20'h002AA;

`ifdef JP_MACRO_MERGE_EN
    localparam bit MERGE = 1'b1;
`else
    localparam bit MERGE = 1'b0;
`endif

    typedef struct {
        logic          start;
        logic          vb;
        logic [VW-1:0] exp_jp;
        logic          exp_busy;
        logic [AW-1:0] exp_step;
        logic          exp_done;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst, vblank, wr_en, start, stop, loop_en;
    logic [VW-1:0] jp_in, jp_out;
    logic [AW-1:0] wr_addr, step;
    logic [EW-1:0] wr_data;
    logic          busy, done;

    int n_vec  = 0;
    int n_miss = 0;

    vec_t          tbl[18];
    logic [VW-1:0] v1, v40, prev, live, done_out;
    logic [VW-1:0] exp_q[$];
    logic [VW-1:0] chg_q[$];
    logic [AW-1:0] step_q[$];
    logic [AW-1:0] prev_step, done_step;
    int            done_seen;
    logic          wrapped;

    logic [VW-1:0] btn_m[5];
    int            dur_m[5];
    logic [VW-1:0] exp_out[256];
    logic          exp_busy[256];
    logic          exp_done[256];

    jp_macro_player #(
        .NUM_PLAYERS(NP),
        .BTN_W(BW),
        .DEPTH(DEPTH),
        .DUR_W(DW)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_vblank(vblank),
        .i_jp_vec(jp_in),
        .i_wr_en(wr_en),
        .i_wr_addr(wr_addr),
        .i_wr_data(wr_data),
        .i_start(start),
        .i_stop(stop),
        .i_loop(loop_en),
        .o_jp_vec(jp_out),
        .o_busy(busy),
        .o_step(step),
        .o_done(done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [VW-1:0] val(input logic [VW-1:0] b, input logic [VW-1:0] l);
        return b | (MERGE ? l : '0);
    endfunction

    task automatic write_entry(input int addr, input logic [DW-1:0] dur, input logic [VW-1:0] btn);
        wr_en   = 1'b1;
        wr_addr = AW'(addr);
        wr_data = {dur, btn};
        tick();
        wr_en   = 1'b0;
    endtask

    function automatic logic vbf(input int c, input int p, input int ph);
        return (c >= 0) && (((c + ph) % p) == 0);
    endfunction

    function automatic logic rise(input int c, input int p, input int ph);
        return vbf(c, p, ph) && !vbf(c - 1, p, ph);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; vblank = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; stop = 1'b0; loop_en = 1'b0; jp_in = '0;
        tick();
        tick();
        check("rst_jp", 32'(jp_out), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_step", 32'(step), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        rst = 1'b0;

        jp_in = 20'h12345;
        tick();
        check("idle_pass", 32'(jp_out), 32'h12345);

        // Basic script: 0x001 for 3 frames, 0x040 for 2 frames, then end marker.
        write_entry(0, 16'd3, 20'h00001);
        write_entry(1, 16'd2, 20'h00040);
        write_entry(2, 16'd0, 20'hFFFFF);
        jp_in = LIVE;
        tick();
        v1  = val(20'h00001, LIVE);
        v40 = val(20'h00040, LIVE);
        tbl[0]  = '{1'b1, 1'b0, LIVE, 1'b1, 4'd0, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, LIVE, 1'b1, 4'd0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, v1,   1'b1, 4'd0, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, v1,   1'b1, 4'd0, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, v1,   1'b1, 4'd0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, v1,   1'b1, 4'd0, 1'b0};
        tbl[6]  = '{1'b0, 1'b0, v1,   1'b1, 4'd0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, v1,   1'b1, 4'd1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, v1,   1'b1, 4'd1, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, v40,  1'b1, 4'd1, 1'b0};
        tbl[10] = '{1'b1, 1'b0, v40,  1'b1, 4'd1, 1'b0};
        tbl[11] = '{1'b0, 1'b1, v40,  1'b1, 4'd1, 1'b0};
        tbl[12] = '{1'b0, 1'b0, v40,  1'b1, 4'd1, 1'b0};
        tbl[13] = '{1'b0, 1'b1, v40,  1'b1, 4'd2, 1'b0};
        tbl[14] = '{1'b0, 1'b0, v40,  1'b1, 4'd2, 1'b0};
        tbl[15] = '{1'b0, 1'b0, v40,  1'b1, 4'd2, 1'b1};
        tbl[16] = '{1'b0, 1'b0, v40,  1'b0, 4'd0, 1'b0};
        tbl[17] = '{1'b0, 1'b0, LIVE, 1'b0, 4'd0, 1'b0};
        for (int i = 0; i < 18; i++) begin
            start  = tbl[i].start;
            vblank = tbl[i].vb;
            tick();
            check($sformatf("tbl_jp[%0d]", i), 32'(jp_out), 32'(tbl[i].exp_jp));
            check($sformatf("tbl_busy[%0d]", i), 32'(busy), 32'(tbl[i].exp_busy));
            check($sformatf("tbl_step[%0d]", i), 32'(step), 32'(tbl[i].exp_step));
            check($sformatf("tbl_done[%0d]", i), 32'(done), 32'(tbl[i].exp_done));
        end
        start = 1'b0; vblank = 1'b0;

        // Looping replay of the same script, then abort.
        jp_in = '0;
        tick();
        loop_en = 1'b1;
        start = 1'b1;
        prev = jp_out;
        chg_q.delete();
        done_seen = 0;
        for (int c = 0; c < 200 && chg_q.size() < 5; c++) begin
            vblank = ((c % 4) == 3);
            tick();
            start = 1'b0;
            if (done) done_seen++;
            if (jp_out !== prev) begin
                chg_q.push_back(jp_out);
                prev = jp_out;
            end
        end
        exp_q = '{20'h00001, 20'h00040, 20'h00001, 20'h00040, 20'h00001};
        for (int i = 0; i < 5; i++) begin
            check($sformatf("loop_seq[%0d]", i),
                  (i < chg_q.size()) ? 32'(chg_q[i]) : 32'hFFFFFFFF, 32'(exp_q[i]));
        end
        stop = 1'b1; vblank = 1'b0;
        tick();
        stop = 1'b0;
        check("stop_busy", 32'(busy), 32'h0);
        check("stop_step", 32'(step), 32'h0);
        for (int c = 0; c < 6; c++) begin
            if (done) done_seen++;
            tick();
        end
        check("loop_no_done", 32'(done_seen), 32'h0);
        loop_en = 1'b0;

        // Start and stop together: stop wins.
        start = 1'b1; stop = 1'b1;
        tick();
        start = 1'b0; stop = 1'b0;
        check("startstop_busy", 32'(busy), 32'h0);
        tick();
        check("startstop_busy2", 32'(busy), 32'h0);

        // Full table without a marker: end path after entry 15.
        for (int k = 0; k < DEPTH; k++) write_entry(k, 16'd1, VW'(k + 1));
        start = 1'b1;
        step_q.delete();
        done_seen = 0; done_step = '0; done_out = '0;
        for (int c = 0; c < 300; c++) begin
            vblank = ((c % 4) == 3);
            tick();
            start = 1'b0;
            if (busy && !done && (step_q.size() == 0 || step_q[$] !== step)) step_q.push_back(step);
            if (done) begin
                done_seen++;
                done_step = step;
                done_out = jp_out;
            end
            if (done_seen > 0 && !busy) break;
        end
        vblank = 1'b0;
        check("wrap_nsteps", 32'(step_q.size()), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("wrap_step[%0d]", i),
                  (i < step_q.size()) ? 32'(step_q[i]) : 32'hFFFFFFFF, 32'(i));
        end
        check("wrap_done_cnt", 32'(done_seen), 32'd1);
        check("wrap_done_step", 32'(done_step), 32'd15);
        check("wrap_done_out", 32'(done_out), 32'h10);

        loop_en = 1'b1;
        start = 1'b1;
        prev_step = '0; wrapped = 1'b0; done_seen = 0;
        for (int c = 0; c < 300; c++) begin
            vblank = ((c % 4) == 3);
            tick();
            start = 1'b0;
            if (done) done_seen++;
            if (busy && prev_step == 4'd15 && step == 4'd0) begin
                wrapped = 1'b1;
                break;
            end
            prev_step = step;
        end
        vblank = 1'b0;
        check("loopwrap_seen", 32'(wrapped), 32'h1);
        check("loopwrap_busy", 32'(busy), 32'h1);
        check("loopwrap_nodone", 32'(done_seen), 32'h0);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("loopwrap_stop", 32'(busy), 32'h0);

        // Marker at entry 0 with loop enabled ends instead of spinning.
        write_entry(0, 16'd0, 20'hFFFFF);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("m0_busy_c0", 32'(busy), 32'h1);
        check("m0_done_c0", 32'(done), 32'h0);
        tick();
        check("m0_done_c1", 32'(done), 32'h0);
        tick();
        check("m0_done_c2", 32'(done), 32'h1);
        tick();
        check("m0_busy_c3", 32'(busy), 32'h0);
        check("m0_done_c3", 32'(done), 32'h0);
        loop_en = 1'b0;

        // Asynchronous reset while holding entry 1.
        write_entry(0, 16'd1, 20'h00001);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        vblank = 1'b1;
        tick();
        vblank = 1'b0;
        tick();
        tick();
        check("pre_rst_step", 32'(step), 32'h1);
        check("pre_rst_jp", 32'(jp_out), 32'h2);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_jp", 32'(jp_out), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_step", 32'(step), 32'h0);
        jp_in = 20'h00155;
        tick();
        rst = 1'b0;
        tick();
        check("post_rst_pass", 32'(jp_out), 32'h155);
        jp_in = 20'h000AA;
        #2;
        check("pass_delay", 32'(jp_out), 32'h155);
        tick();
        check("pass_next", 32'(jp_out), 32'h0AA);

        // Live presses during playback.
        write_entry(0, 16'd1, 20'h00010);
        write_entry(1, 16'd0, 20'h00000);
        jp_in = 20'h00001;
        tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("merge_jp", 32'(jp_out), MERGE ? 32'h011 : 32'h010);
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // Randomized scripts against a frame-timeline model.
        for (int run = 0; run < 20; run++) begin
            int n_ent, per, ph, a, r, t_end, done_at, seen;
            n_ent = $urandom_range(1, 5);
            for (int k = 0; k < n_ent; k++) begin
                btn_m[k] = VW'($urandom);
                dur_m[k] = $urandom_range(1, 3);
                write_entry(k, DW'(dur_m[k]), btn_m[k]);
            end
            write_entry(n_ent, '0, VW'($urandom));
            live = VW'($urandom);
            per  = $urandom_range(2, 7);
            ph   = $urandom_range(0, per - 1);
            jp_in = live; vblank = 1'b0;
            tick();
            for (int c = 0; c < 256; c++) begin
                exp_out[c] = live;
                exp_busy[c] = 1'b0;
                exp_done[c] = 1'b0;
            end
            a = 2; t_end = 0; done_at = 0;
            for (int k = 0; k < n_ent; k++) begin
                seen = 0;
                r = a;
                while (seen < dur_m[k]) begin
                    r++;
                    if (rise(r, per, ph)) seen++;
                end
                if (k < n_ent - 1) begin
                    for (int c = a; c <= r + 1; c++) exp_out[c] = val(btn_m[k], live);
                    a = r + 2;
                end else begin
                    for (int c = a; c <= r + 3; c++) exp_out[c] = val(btn_m[k], live);
                    done_at = r + 2;
                    t_end = r + 8;
                end
            end
            for (int c = 0; c <= done_at; c++) exp_busy[c] = 1'b1;
            exp_done[done_at] = 1'b1;
            for (int c = 0; c < t_end; c++) begin
                start  = (c == 0);
                vblank = vbf(c, per, ph);
                tick();
                check($sformatf("rnd%0d_jp[%0d]", run, c), 32'(jp_out), 32'(exp_out[c]));
                check($sformatf("rnd%0d_busy[%0d]", run, c), 32'(busy), 32'(exp_busy[c]));
                check($sformatf("rnd%0d_done[%0d]", run, c), 32'(done), 32'(exp_done[c]));
            end
            start = 1'b0; vblank = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
